// File: rtl/maxpool2x2.sv
// maxpool2x2: 2x2 stride-2 signed max-pool between activation and pool BRAMs.
// Define MAXPOOL_FUSED_RELU_EN to clamp negative pooled results to zero.
module maxpool2x2 #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IMG_SIZE   = 28,
  parameter int RD_LAT     = 2,
  localparam int OUT   = IMG_SIZE / 2,
  localparam int N_OUT = CHANNELS * OUT * OUT,
  localparam int AWI   = $clog2(CHANNELS * IMG_SIZE * IMG_SIZE),
  localparam int AWO   = $clog2(N_OUT)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  output logic                         busy,
  output logic [AWI-1:0]               conv_r_addr,
  output logic                         conv_r_en,
  input  logic signed [DATA_WIDTH-1:0] conv_r_q,
  output logic [AWO-1:0]               pool_w_addr,
  output logic                         pool_w_en,
  output logic                         pool_w_we,
  output logic [DATA_WIDTH-1:0]        pool_w_d,
  output logic                         done
);

  localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int OW = (OUT > 1) ? $clog2(OUT) : 1;

  localparam logic [AWI-1:0] IMG_A   = AWI'(IMG_SIZE);
  localparam logic [AWI-1:0] IMG2_A  = AWI'(2 * IMG_SIZE);
  localparam logic [AWI-1:0] PLANE_A = AWI'(IMG_SIZE * IMG_SIZE);
  localparam logic [AWO-1:0] LAST_W  = AWO'(N_OUT - 1);
  localparam logic [OW-1:0]  QMAX    = OW'(OUT - 1);
  localparam logic [WW-1:0]  WMAX    = WW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, RD, WAIT, CAP, WR, FINISH
  } state_t;

  state_t state_q, state_d;

  logic [1:0]     k;
  logic [WW-1:0]  wcnt;
  logic [OW-1:0]  q, r;
  logic [AWI-1:0] cb, rb, chb;
  logic [AWI-1:0] ra;
  logic [AWO-1:0] wa;
  logic signed [DATA_WIDTH-1:0] mx;
  logic           last;

  function automatic logic [AWI-1:0] rd_off(input logic [1:0] kk);
    return (kk[1] ? IMG_A : '0) + AWI'(kk[0]);
  endfunction

  assign last        = (wa == LAST_W);
  assign busy        = (state_q != IDLE);
  assign conv_r_en   = (state_q == RD);
  assign pool_w_en   = (state_q == WR);
  assign pool_w_we   = pool_w_en;
  assign conv_r_addr = ra;
  assign pool_w_addr = wa;

`ifdef MAXPOOL_FUSED_RELU_EN
  assign pool_w_d = mx[DATA_WIDTH-1] ? '0 : mx;
`else
  assign pool_w_d = mx;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: four reads per window, then one write
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RD;
      RD:      state_d = WAIT;
      WAIT:    if (wcnt == WMAX) state_d = CAP;
      CAP:     state_d = (k == 2'd3) ? WR : RD;
      WR:      state_d = last ? FINISH : RD;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window walk, read address, running max, write address
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k    <= '0;
      wcnt <= '0;
      q    <= '0;
      r    <= '0;
      cb   <= '0;
      rb   <= '0;
      chb  <= '0;
      ra   <= '0;
      wa   <= '0;
      mx   <= '0;
      done <= 1'b0;
    end else begin
      done <= (state_q == FINISH);
      unique case (state_q)
        IDLE: if (start) begin
          k    <= '0;
          wcnt <= '0;
          q    <= '0;
          r    <= '0;
          cb   <= '0;
          rb   <= '0;
          chb  <= '0;
          ra   <= '0;
          wa   <= '0;
        end
        RD:   wcnt <= '0;
        WAIT: wcnt <= wcnt + WW'(1);
        CAP: begin
          if (k == 2'd0 || conv_r_q > mx) mx <= conv_r_q;
          k <= k + 2'd1;
          if (k != 2'd3) begin
            ra <= rb + cb + rd_off(k + 2'd1);
          end else if (!last) begin
            if (q == QMAX) begin
              q  <= '0;
              cb <= '0;
              if (r == QMAX) begin
                r   <= '0;
                chb <= chb + PLANE_A;
                rb  <= chb + PLANE_A;
              end else begin
                r  <= r + OW'(1);
                rb <= rb + IMG2_A;
              end
            end else begin
              q  <= q + OW'(1);
              cb <= cb + AWI'(2);
            end
          end
        end
        WR: if (!last) begin
          wa <= wa + AWO'(1);
          ra <= rb + cb;
        end
        default: ;
      endcase
    end
  end

endmodule
